// File: rtl/mem_arbiter.sv
// mem_arbiter: owns the single byte-wide RAM port and serves two requesters,
// instruction fetch (always 4-byte reads) and the load/store buffer (1/2/4-byte
// loads and stores). Multi-byte accesses are sequenced one byte per cycle and
// assembled little-endian. Pipeline clear aborts reads but never stores.
//
// Build option: define MEM_ARB_RR_EN for round-robin arbitration between the
// two requesters; otherwise load/store has fixed priority over fetch.
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        LS_RD = 2'd2,
        LS_WR = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;

    // Sequencing registers
    logic [2:0]        r_cnt, w_cnt_nxt;      // bytes issued so far (0..4)
    logic [2:0]        r_len, w_len_nxt;      // access length in bytes (1, 2, 4)
    logic [ADDR_W-1:0] r_base, w_base_nxt;
    logic [31:0]       r_acc, w_acc_nxt;
    logic [31:0]       r_wdata, w_wdata_nxt;

    // Registered outputs
    logic [ADDR_W-1:0] r_mem_a, w_mem_a_nxt;
    logic [7:0]        r_mem_dout, w_mem_dout_nxt;
    logic              r_mem_wr, w_mem_wr_nxt;
    logic              r_if_done, w_if_done_nxt;
    logic              r_ls_done, w_ls_done_nxt;
    logic [31:0]       r_if_data, w_if_data_nxt;
    logic [31:0]       r_ls_rdata, w_ls_rdata_nxt;

    // Helpers
    logic [2:0]        w_ls_len;
    logic              w_can_grant;
    logic              w_grant_if;
    logic              w_grant_ls;
    logic [2:0]        w_cnt_p1;
    logic              w_issue;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [1:0]        w_cap_idx;
    logic [31:0]       w_acc_merge;
    logic [7:0]        w_wbyte;

    // Requested load/store length; size 3 is folded onto 4 bytes
    always_comb begin
        case (ls_size)
            2'd0:    w_ls_len = 3'd1;
            2'd1:    w_ls_len = 3'd2;
            default: w_ls_len = 3'd4;
        endcase
    end

    // No new grant while flushing or while a completion pulse is still visible
    assign w_can_grant = (r_state == IDLE) && !clear && !r_if_done && !r_ls_done;

`ifdef MEM_ARB_RR_EN
    logic r_last_ls;

    // On conflict, the requester that was not served last wins
    assign w_grant_if = w_can_grant && if_req && (!ls_req || r_last_ls);
    assign w_grant_ls = w_can_grant && ls_req && (!if_req || !r_last_ls);

    // Remember who completed last; reset value makes fetch win the first tie
    always_ff @(posedge clk) begin
        if (rst)
            r_last_ls <= 1'b1;
        else if (rdy) begin
            if (w_ls_done_nxt)
                r_last_ls <= 1'b1;
            else if (w_if_done_nxt)
                r_last_ls <= 1'b0;
        end
    end
`else
    // Load/store always wins; fetch only goes when load/store is quiet
    assign w_grant_ls = w_can_grant && ls_req;
    assign w_grant_if = w_can_grant && if_req && !ls_req;
`endif

    assign w_cnt_p1   = r_cnt + 3'd1;
    assign w_issue    = (w_cnt_p1 < r_len);
    assign w_addr_nxt = r_base + ADDR_W'(w_cnt_p1);
    // Byte returning this cycle was issued one cycle earlier (index cnt-1)
    assign w_cap_idx  = r_cnt[1:0] - 2'd1;

    // Accumulator with the returning RAM byte dropped into its lane
    always_comb begin
        w_acc_merge = r_acc;
        for (int b = 0; b < 4; b++) begin
            if (w_cap_idx == 2'(b))
                w_acc_merge[8*b +: 8] = mem_din;
        end
    end

    // Store byte for the next issue slot
    always_comb begin
        case (w_cnt_p1[1:0])
            2'd0:    w_wbyte = r_wdata[7:0];
            2'd1:    w_wbyte = r_wdata[15:8];
            2'd2:    w_wbyte = r_wdata[23:16];
            default: w_wbyte = r_wdata[31:24];
        endcase
    end

    // Next-state and next-output logic; outputs default to the idle value
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_len_nxt      = r_len;
        w_base_nxt     = r_base;
        w_acc_nxt      = r_acc;
        w_wdata_nxt    = r_wdata;
        w_mem_a_nxt    = '0;
        w_mem_dout_nxt = 8'h00;
        w_mem_wr_nxt   = 1'b0;
        w_if_done_nxt  = 1'b0;
        w_ls_done_nxt  = 1'b0;
        w_if_data_nxt  = 32'h0;
        w_ls_rdata_nxt = 32'h0;

        case (r_state)
            IDLE: begin
                if (w_grant_if) begin
                    w_state_nxt = IF_RD;
                    w_base_nxt  = if_addr;
                    w_len_nxt   = 3'd4;
                    w_cnt_nxt   = 3'd0;
                    w_acc_nxt   = 32'h0;
                    w_mem_a_nxt = if_addr;
                end else if (w_grant_ls) begin
                    w_base_nxt  = ls_addr;
                    w_len_nxt   = w_ls_len;
                    w_cnt_nxt   = 3'd0;
                    w_acc_nxt   = 32'h0;
                    w_wdata_nxt = ls_wdata;
                    w_mem_a_nxt = ls_addr;
                    if (ls_we) begin
                        w_state_nxt    = LS_WR;
                        w_mem_wr_nxt   = 1'b1;
                        w_mem_dout_nxt = ls_wdata[7:0];
                    end else begin
                        w_state_nxt = LS_RD;
                    end
                end
            end

            IF_RD, LS_RD: begin
                if (clear) begin
                    // Speculative read is dropped, including a completing one
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 3'd0;
                end else begin
                    if (r_cnt != 3'd0)
                        w_acc_nxt = w_acc_merge;
                    if (w_issue)
                        w_mem_a_nxt = w_addr_nxt;
                    w_cnt_nxt = w_cnt_p1;
                    if (r_cnt == r_len) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = 3'd0;
                        if (r_state == IF_RD) begin
                            w_if_done_nxt = 1'b1;
                            w_if_data_nxt = w_acc_merge;
                        end else begin
                            w_ls_done_nxt  = 1'b1;
                            w_ls_rdata_nxt = w_acc_merge;
                        end
                    end
                end
            end

            LS_WR: begin
                // Committed store: clear has no effect here
                if (w_issue) begin
                    w_mem_a_nxt    = w_addr_nxt;
                    w_mem_dout_nxt = w_wbyte;
                    w_mem_wr_nxt   = 1'b1;
                    w_cnt_nxt      = w_cnt_p1;
                end else begin
                    w_state_nxt   = IDLE;
                    w_cnt_nxt     = 3'd0;
                    w_ls_done_nxt = 1'b1;
                end
            end

            default: w_state_nxt = IDLE;
        endcase
    end

    // State register; rdy low freezes the FSM
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else if (rdy)
            r_state <= w_state_nxt;
    end

    // Datapath and output registers, frozen together with the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= 3'd0;
            r_len      <= 3'd0;
            r_base     <= '0;
            r_acc      <= 32'h0;
            r_wdata    <= 32'h0;
            r_mem_a    <= '0;
            r_mem_dout <= 8'h00;
            r_mem_wr   <= 1'b0;
            r_if_done  <= 1'b0;
            r_ls_done  <= 1'b0;
            r_if_data  <= 32'h0;
            r_ls_rdata <= 32'h0;
        end else if (rdy) begin
            r_cnt      <= w_cnt_nxt;
            r_len      <= w_len_nxt;
            r_base     <= w_base_nxt;
            r_acc      <= w_acc_nxt;
            r_wdata    <= w_wdata_nxt;
            r_mem_a    <= w_mem_a_nxt;
            r_mem_dout <= w_mem_dout_nxt;
            r_mem_wr   <= w_mem_wr_nxt;
            r_if_done  <= w_if_done_nxt;
            r_ls_done  <= w_ls_done_nxt;
            r_if_data  <= w_if_data_nxt;
            r_ls_rdata <= w_ls_rdata_nxt;
        end
    end

    assign mem_a    = r_mem_a;
    assign mem_dout = r_mem_dout;
    // The write strobe must not fire while the RAM is frozen
    assign mem_wr   = r_mem_wr & rdy;
    assign if_done  = r_if_done;
    assign if_data  = r_if_data;
    assign ls_done  = r_ls_done;
    assign ls_rdata = r_ls_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 64 KiB synchronous byte RAM model
// (1-cycle read latency, frozen by rdy like the real RAM).
module tb_mem_arbiter;

    localparam int AW = 32;
`ifdef MEM_ARB_RR_EN
    localparam logic [15:0] ARB_EXP = 16'h1212;  // IF, LS, IF, LS
`else
    localparam logic [15:0] ARB_EXP = 16'h2211;  // LS, LS, IF, IF
`endif

    logic          clk = 1'b0;
    logic          rst, rdy, clear;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_done;
    logic [31:0]   if_data;
    logic          ls_req, ls_we;
    logic [1:0]    ls_size;
    logic [AW-1:0] ls_addr;
    logic [31:0]   ls_wdata;
    logic          ls_done;
    logic [31:0]   ls_rdata;
    logic [7:0]    mem_din, mem_dout;
    logic [AW-1:0] mem_a;
    logic          mem_wr;

    logic [7:0]    ram [0:65535];
    logic          pl_we;
    logic [15:0]   pl_a;
    logic [7:0]    pl_d;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    // RAM model: preload port has priority, otherwise frozen when rdy=0
    always @(posedge clk) begin
        if (pl_we)
            ram[pl_a] <= pl_d;
        else if (rdy) begin
            if (mem_wr)
                ram[mem_a[15:0]] <= mem_dout;
            mem_din <= ram[mem_a[15:0]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        pl_a = a; pl_d = d; pl_we = 1'b1;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // Edges after acceptance until the selected done pulse is seen
    task automatic wait_done(input bit is_if, input int lim, output int n);
        n = 0;
        forever begin
            cyc();
            if (is_if ? if_done : ls_done) break;
            n++;
            if (n > lim) begin
                n_cmp++; n_err++;
                $display("FAIL wait_done: no done within %0d cycles", lim);
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ni, nl, nd, done_k;
        logic [15:0] code;

        rst = 1'b1; rdy = 1'b1; clear = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'd0; ls_addr = '0; ls_wdata = '0;
        pl_we = 1'b0; pl_a = '0; pl_d = '0;
        cyc();
        poke(16'h0100, 8'h13); poke(16'h0101, 8'h05);
        poke(16'h0102, 8'hA0); poke(16'h0103, 8'h00);
        poke(16'h0030, 8'h80);
        poke(16'h2000, 8'h00); poke(16'h2001, 8'h00); poke(16'h2002, 8'h77);
        poke(16'h0040, 8'h11); poke(16'h0041, 8'h22);
        poke(16'h0042, 8'h33); poke(16'h0043, 8'h44);
        poke(16'hFFFF, 8'hAB); poke(16'h0000, 8'hCD);

        // Reset state
        chk("rst_ctl", {if_done, ls_done, mem_wr, mem_a, mem_dout}, 64'h0);
        chk("rst_data", {if_data, ls_rdata}, 64'h0);
        rst = 1'b0;
        cyc();

        // 4-byte fetch
        if_req = 1'b1; if_addr = 32'h100;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("if_walk", {if_done, mem_wr, mem_a}, {2'b00, 32'h100 + 32'(k)});
        end
        cyc();
        chk("if_a_idle", {if_done, mem_a}, 33'h0);
        cyc();
        chk("if_done", if_done, 1);
        chk("if_data", if_data, 32'h00A00513);
        if_req = 1'b0;
        cyc();
        chk("if_pulse", if_done, 0);

        // Halfword store
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd1; ls_addr = 32'h2000; ls_wdata = 32'hDEADBEEF;
        cyc();
        chk("sh_b0", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h2000, 8'hEF});
        cyc();
        chk("sh_b1", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h2001, 8'hBE});
        cyc();
        chk("sh_done", {ls_done, mem_wr, mem_a}, {2'b10, 32'h0});
        ls_req = 1'b0;
        cyc();
        chk("sh_ram", {ram[16'h2002], ram[16'h2001], ram[16'h2000]}, {8'h77, 8'hBE, 8'hEF});

        // Byte load
        ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h30; ls_req = 1'b1;
        cyc();
        chk("lb_a", mem_a, 32'h30);
        cyc();
        chk("lb_wait", {ls_done, mem_a}, 33'h0);
        cyc();
        chk("lb_done", {ls_done, ls_rdata}, {1'b1, 32'h00000080});
        ls_req = 1'b0;
        cyc();

        // Halfword load wrapping across the top of the address space
        ls_size = 2'd1; ls_addr = 32'hFFFFFFFF; ls_req = 1'b1;
        cyc();
        chk("wrap_a0", mem_a, 32'hFFFFFFFF);
        cyc();
        chk("wrap_a1", mem_a, 32'h0);
        cyc();
        chk("wrap_wait", ls_done, 0);
        cyc();
        chk("wrap_done", {ls_done, ls_rdata}, {1'b1, 32'h0000CDAB});
        ls_req = 1'b0;
        cyc();

        // Size 3 behaves as a word
        ls_size = 2'd3; ls_addr = 32'h40; ls_req = 1'b1;
        wait_done(1'b0, 20, n);
        chk("sz3_lat", n, 5);
        chk("sz3_data", ls_rdata, 32'h44332211);
        ls_req = 1'b0;
        cyc();

        // Contention: two transactions per requester
        if_addr = 32'h100; ls_addr = 32'h40; ls_size = 2'd2; ls_we = 1'b0;
        if_req = 1'b1; ls_req = 1'b1;
        code = 16'h0; ni = 0; nl = 0;
        for (int k = 0; k < 80 && (ni < 2 || nl < 2); k++) begin
            cyc();
            if (if_done) begin
                code = {code[11:0], 4'h1};
                chk("arb_if_data", if_data, 32'h00A00513);
                ni++;
                if (ni == 2) if_req = 1'b0;
            end
            if (ls_done) begin
                code = {code[11:0], 4'h2};
                chk("arb_ls_data", ls_rdata, 32'h44332211);
                nl++;
                if (nl == 2) ls_req = 1'b0;
            end
        end
        chk("arb_order", code, ARB_EXP);
        if_req = 1'b0; ls_req = 1'b0;
        cyc();

        // Clear on the second cycle of a fetch
        if_req = 1'b1; if_addr = 32'h100;
        cyc();
        clear = 1'b1; if_req = 1'b0;
        cyc();
        chk("clr_a", {if_done, mem_a}, 33'h0);
        clear = 1'b0;
        nd = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (if_done) nd++;
        end
        chk("clr_nodone", nd, 0);
        // Back in IDLE: a byte load completes with normal latency
        ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h30; ls_req = 1'b1;
        wait_done(1'b0, 20, n);
        chk("clr_idle_lat", n, 2);
        chk("clr_idle_data", ls_rdata, 32'h80);
        ls_req = 1'b0;
        cyc();

        // Clear mid word-store is ignored
        ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h2100; ls_wdata = 32'h12345678; ls_req = 1'b1;
        cyc();
        cyc();
        chk("sw_b1", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h2101, 8'h56});
        clear = 1'b1;
        cyc();
        chk("sw_b2", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h2102, 8'h34});
        clear = 1'b0;
        cyc();
        chk("sw_b3", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h2103, 8'h12});
        cyc();
        chk("sw_done", {ls_done, mem_wr}, 2'b10);
        ls_req = 1'b0;
        cyc();
        chk("sw_ram", {ram[16'h2103], ram[16'h2102], ram[16'h2101], ram[16'h2100]}, 32'h12345678);

        // rdy low for 3 cycles during a word load
        ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'h40; ls_req = 1'b1;
        done_k = -1;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (k >= 2 && k <= 4)
                chk("rdy_hold", {mem_wr, ls_done, mem_a}, {2'b00, 32'h41});
            if (k == 1) rdy = 1'b0;
            if (k == 4) rdy = 1'b1;
            if (ls_done) begin
                done_k = k;
                break;
            end
        end
        chk("rdy_lat", done_k, 8);
        chk("rdy_data", ls_rdata, 32'h44332211);
        ls_req = 1'b0; rdy = 1'b1;
        cyc();

        // Store frozen by rdy, then reset mid-write
        ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h2200; ls_wdata = 32'hAABBCCDD; ls_req = 1'b1;
        cyc();
        chk("rw_b0", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h2200, 8'hDD});
        rdy = 1'b0;
        cyc();
        chk("rw_frozen", {mem_wr, mem_a, mem_dout}, {1'b0, 32'h2200, 8'hDD});
        rdy = 1'b1;
        cyc();
        chk("rw_b1", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h2201, 8'hCC});
        rst = 1'b1; ls_req = 1'b0;
        cyc();
        chk("rw_rst_ctl", {if_done, ls_done, mem_wr, mem_a, mem_dout}, 64'h0);
        chk("rw_rst_data", {if_data, ls_rdata}, 64'h0);
        rst = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
